// File: rtl/cellrv32_package.sv
// Shared types and helpers for the cellrv32 Wishbone responder slice.
package cellrv32_package;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_resp_state_t;

    // Number of address bits needed to index input_size entries (ceil(log2)).
    function automatic int index_size_f(input int input_size);
        int r;
        r = 0;
        while ((1 << r) < input_size) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cellrv32_wb_resp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module cellrv32_wb_resp_ram #(
    parameter int WORDS = 256,
    parameter int IW    = 8
) (
    input  logic          clk_i,
    input  logic [IW-1:0] addr_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Read returns the contents before a write to the same word on the same edge.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cellrv32_wb_responder.sv
// Wishbone responder serving a local word RAM with programmable response latency.
// Optional user-mode write rejection is enabled by defining CELLRV32_WB_RESP_PRIV_CHECK_EN.
module cellrv32_wb_responder
    import cellrv32_package::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int          MEM_SIZE  = 1024,
    parameter int          LATENCY   = 0,
    parameter logic        PIPE_MODE = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  wb_tag_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int AW    = index_size_f(MEM_SIZE);
    localparam int IW    = AW - 2;
    localparam int WORDS = MEM_SIZE / 4;

    wb_resp_state_t state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          ok_q, ok_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic          req;
    logic          hit;
    logic          rej;
    logic [IW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic          unused_sig;

    assign req = wb_cyc_i & wb_stb_i;
    assign hit = (wb_adr_i[31:AW] == BASE_ADDR[31:AW]);

`ifdef CELLRV32_WB_RESP_PRIV_CHECK_EN
    assign rej        = wb_we_i & ~wb_tag_i[0];
    assign unused_sig = ^{wb_tag_i[2:1], wb_adr_i[1:0], PIPE_MODE};
`else
    assign rej        = 1'b0;
    assign unused_sig = ^{wb_tag_i, wb_adr_i[1:0], PIPE_MODE};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        ok_d    = ok_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d   = wb_we_i;
                    addr_d = wb_adr_i[AW-1:2];
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    ok_d   = hit & ~rej;
                    cnt_d  = 8'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        ack_d   = hit & ~rej;
                        err_d   = ~(hit & ~rej);
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Dropping CYC abandons the transaction before anything is committed.
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q <= 8'd1) begin
                    state_d = RESP;
                    cnt_d   = 8'd0;
                    ack_d   = ok_q;
                    err_d   = ~ok_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 4'd0;
            wdat_q  <= 32'd0;
            ok_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ok_q    <= ok_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // The read is launched on the accepting edge so data is ready even with zero latency.
    assign ram_addr = (state_q == IDLE) ? wb_adr_i[AW-1:2] : addr_q;
    assign ram_we   = (state_q == RESP) & ack_q & we_q & wb_cyc_i;

    cellrv32_wb_resp_ram #(
        .WORDS (WORDS),
        .IW    (IW)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (sel_q),
        .wdata_i (wdat_q),
        .rdata_o (ram_rdata)
    );

    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_err_o = err_q & wb_cyc_i;
    assign wb_dat_o = (wb_ack_o & ~we_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_cellrv32_wb_responder.sv
// Bench for cellrv32_wb_responder: a zero-latency classic instance and a latency-3 pipelined
// instance share one bus, each selected by its own CYC, checked against a word-array memory model.
module tb_cellrv32_wb_responder;

    localparam logic [31:0] BASE  = 32'h9000_0000;
    localparam int          LAT_A = 0;
    localparam int          LAT_B = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  tag;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc_a;
    logic        cyc_b;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_a [256];
    logic [31:0] model_b [256];

    always #5 clk = ~clk;

    cellrv32_wb_responder #(
        .BASE_ADDR (BASE),
        .MEM_SIZE  (1024),
        .LATENCY   (LAT_A),
        .PIPE_MODE (1'b0)
    ) dut_a (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_tag_i (tag),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc_a),
        .wb_dat_o (dat_a),
        .wb_ack_o (ack_a),
        .wb_err_o (err_a)
    );

    cellrv32_wb_responder #(
        .BASE_ADDR (BASE),
        .MEM_SIZE  (1024),
        .LATENCY   (LAT_B),
        .PIPE_MODE (1'b1)
    ) dut_b (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_tag_i (tag),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc_b),
        .wb_dat_o (dat_b),
        .wb_ack_o (ack_b),
        .wb_err_o (err_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // One transaction on DUT d (0 = classic/LAT_A, 1 = pipelined/LAT_B).
    // abort_at > 0 drops CYC in that wait cycle; hold_cyc keeps CYC up afterwards.
    task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic [2:0] tg, input int abort_at, input bit hold_cyc);
        int          lat;
        int          n;
        bit          done;
        bit          pipe;
        logic        ok;
        logic        ack_s, err_s;
        logic [31:0] dat_s;
        logic [31:0] exp_rd;
        logic [7:0]  widx;

        lat    = (d == 0) ? LAT_A : LAT_B;
        pipe   = (d == 1);
        widx   = a[9:2];
        ok     = (a[31:10] == BASE[31:10]);
`ifdef CELLRV32_WB_RESP_PRIV_CHECK_EN
        if (w && !tg[0]) ok = 1'b0;
`endif
        exp_rd = (d == 0) ? model_a[widx] : model_b[widx];

        @(negedge clk);
        ack_s = (d == 0) ? ack_a : ack_b;
        err_s = (d == 0) ? err_a : err_b;
        checkOutput("idle_quiet", {30'd0, ack_s, err_s}, 32'd0);
        we = w; adr = a; wdat = wd; sel = be; tag = tg; stb = 1'b1;
        if (d == 0) cyc_a = 1'b1; else cyc_b = 1'b1;

        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            ack_s = (d == 0) ? ack_a : ack_b;
            err_s = (d == 0) ? err_a : err_b;
            dat_s = (d == 0) ? dat_a : dat_b;
            if (ack_s || err_s) begin
                checkOutput("latency", 32'(n), 32'(lat + 1));
                checkOutput("ack", {31'd0, ack_s}, {31'd0, ok});
                checkOutput("err", {31'd0, err_s}, {31'd0, ~ok});
                if (!w) checkOutput("rdata", dat_s, ok ? exp_rd : 32'd0);
                if (!ack_s) checkOutput("err_dat_zero", dat_s, 32'd0);
                if (ok && w) begin
                    if (d == 0) model_a[widx] = merge(model_a[widx], wd, be);
                    else        model_b[widx] = merge(model_b[widx], wd, be);
                end
                done = 1'b1;
                @(posedge clk);
                #1;
                stb = 1'b0;
                if (!hold_cyc) begin
                    cyc_a = 1'b0;
                    cyc_b = 1'b0;
                end
            end else if (abort_at > 0 && n == abort_at) begin
                cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0;
                repeat (lat + 2) begin
                    @(negedge clk);
                    ack_s = (d == 0) ? ack_a : ack_b;
                    err_s = (d == 0) ? err_a : err_b;
                    checkOutput("abort_quiet", {30'd0, ack_s, err_s}, 32'd0);
                end
                done = 1'b1;
            end else if (n > lat + 4) begin
                checkOutput("timeout", 32'(n), 32'(lat + 1));
                stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
                done = 1'b1;
            end else if (pipe) begin
                // Single-cycle STB, then a stray STB during WAIT that must be ignored.
                if (n == 1) stb = 1'b0;
                if (n == 2 && lat >= 3) begin
                    stb = 1'b1;
                    adr = a ^ 32'h0000_0004;
                end
                if (n == 3 && lat >= 3) stb = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        int          dsel;
        int          abort_at;

        rst = 1'b1; stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
        we = 1'b0; adr = 32'd0; wdat = 32'd0; sel = 4'd0; tag = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_a", {dat_a[29:0], ack_a, err_a}, 32'd0);
        checkOutput("rst_b", {dat_b[29:0], ack_b, err_b}, 32'd0);
        checkOutput("rst_dat_a", dat_a, 32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 3'b001, 0, 1'b0);
            applyStimulus(1, 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 3'b001, 0, 1'b0);
        end

        applyStimulus(0, 1'b1, 32'h9000_0010, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 1'b0);
        applyStimulus(0, 1'b0, 32'h9000_0010, 32'd0, 4'hF, 3'b001, 0, 1'b0);
        checkOutput("model_deadbeef", model_a[4], 32'hDEAD_BEEF);

        applyStimulus(1, 1'b1, 32'h9000_0020, 32'h1111_1111, 4'hF, 3'b001, 0, 1'b0);
        applyStimulus(1, 1'b1, 32'h9000_0020, 32'h0000_AB00, 4'b0010, 3'b001, 0, 1'b0);
        applyStimulus(1, 1'b0, 32'h9000_0020, 32'd0, 4'hF, 3'b001, 0, 1'b0);

        applyStimulus(0, 1'b0, 32'h9000_0400, 32'd0, 4'hF, 3'b001, 0, 1'b0);
        applyStimulus(0, 1'b1, 32'h8000_0010, 32'h5555_5555, 4'hF, 3'b001, 0, 1'b0);
        applyStimulus(0, 1'b0, 32'h9000_0010, 32'd0, 4'hF, 3'b001, 0, 1'b0);

        applyStimulus(1, 1'b1, 32'h9000_0024, 32'hA5A5_A5A5, 4'hF, 3'b001, 2, 1'b0);
        applyStimulus(1, 1'b0, 32'h9000_0024, 32'd0, 4'hF, 3'b001, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b0, BASE + 32'(i * 4), 32'd0, 4'hF, 3'b001, 0, (i != 3));
        end

        applyStimulus(0, 1'b1, 32'h9000_0030, 32'h1234_5678, 4'hF, 3'b000, 0, 1'b0);
        applyStimulus(0, 1'b0, 32'h9000_0030, 32'd0, 4'hF, 3'b000, 0, 1'b0);
        applyStimulus(0, 1'b1, 32'h9000_0030, 32'hCAFE_F00D, 4'hF, 3'b001, 0, 1'b0);
        applyStimulus(0, 1'b0, 32'h9000_0030, 32'd0, 4'hF, 3'b000, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            dsel = int'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 85) begin
                ra = BASE + 32'($urandom_range(0, 15) * 4);
            end else begin
                ra = $urandom;
                if (ra[31:10] == BASE[31:10]) ra[31] = ~ra[31];
            end
            abort_at = 0;
            if (dsel == 1 && $urandom_range(0, 9) == 0) abort_at = int'($urandom_range(1, LAT_B));
            applyStimulus(dsel, 1'($urandom), ra, $urandom, 4'($urandom), 3'($urandom),
                          abort_at, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
